deserialize: RTL and testbench

DESERIALIZE -- requirements
Module: deserialize

---
 rtl/deserialize.sv | 80 ++++++++
 tb/tb_deserialize.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/deserialize.sv
// Serial-to-parallel word collector.
// Collects LENGTH words of BIT_WIDTH bits into one vector and holds the
// finished vector in an output buffer until the consumer takes it. The next
// vector keeps filling while the buffer is held. The input stalls only when
// the next vector would complete while the buffer is still waiting.
module deserialize #(
  parameter int LENGTH    = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [BIT_WIDTH-1:0]          in,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LENGTH*BIT_WIDTH-1:0]   out,
  output logic [$clog2(LENGTH)-1:0]     count
);

  localparam int CW      = $clog2(LENGTH);
  localparam int VW      = LENGTH * BIT_WIDTH;
  localparam int LOW_W   = (LENGTH - 1) * BIT_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  logic [VW-1:0] sr;
  logic [VW-1:0] obuf;
  logic [CW-1:0] cnt;
  logic          ovalid;

  logic          accept;
  logic          complete;

  // A word may enter unless it would complete a vector that has nowhere to go.
  always_comb begin
    in_ready = !((cnt == CNT_LAST) && ovalid && !out_ready);
    accept   = in_valid && in_ready;
    complete = accept && (cnt == CNT_LAST);
  end

  assign out       = obuf;
  assign out_valid = ovalid;
  assign count     = cnt;

  // Shift register, word counter, output buffer and its valid flag.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking assignments would let the
  // obuf capture see an sr that has already shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      obuf   <= '0;
      cnt    <= '0;
      ovalid <= 1'b0;
    end else if (clear) begin
      // Clear beats everything, including a word offered in the same cycle.
      sr     <= '0;
      cnt    <= '0;
      ovalid <= 1'b0;
    end else begin
      if (accept) begin
        sr <= {sr[LOW_W-1:0], in};
        if (complete) begin
          obuf <= {sr[LOW_W-1:0], in};
          cnt  <= '0;
        end else begin
          cnt  <= cnt + CW'(1);
        end
      end
      // A new vector landing in the same cycle as a drain keeps valid high.
      if (complete) begin
        ovalid <= 1'b1;
      end else if (ovalid && out_ready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserialize.sv
// Directed bench for deserialize: a LENGTH=4 instance for the handshake
// scenarios and a LENGTH=32 instance for the serialize/deserialize round trip.
module tb_deserialize;

  localparam int BW = 16;

  logic clk;
  logic rst;

  // LENGTH = 4 instance
  logic          clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [BW-1:0] in_a;
  logic [63:0]   out_a;
  logic [1:0]    count_a;

  // LENGTH = 32 instance
  logic          clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [BW-1:0] in_b;
  logic [511:0]  out_b;
  logic [4:0]    count_b;

  int n_checks = 0;
  int n_fail   = 0;

  deserialize #(.LENGTH(4), .BIT_WIDTH(BW)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a),
    .in_valid(in_valid_a), .in(in_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out(out_a), .count(count_a)
  );

  deserialize #(.LENGTH(32), .BIT_WIDTH(BW)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b),
    .in_valid(in_valid_b), .in(in_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out(out_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and step just past it so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input logic [BW-1:0] w);
    in_valid_a = 1'b1;
    in_a       = w;
    tick();
    in_valid_a = 1'b0;
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] w0, w1, w2, w3);
    return {w0, w1, w2, w3};
  endfunction

  logic [511:0] vec;

  initial begin
    rst = 1'b1;
    clear_a = 1'b0; in_valid_a = 1'b0; in_a = '0; out_ready_a = 1'b0;
    clear_b = 1'b0; in_valid_b = 1'b0; in_b = '0; out_ready_b = 1'b0;
    vec = '0;
    repeat (2) tick();

    // Reset state
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out", out_a, 0);
    check("rst_count", count_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    rst = 1'b0;
    tick();

    // Basic: four words with out_ready low
    feed_a(16'h0001);
    feed_a(16'h0002);
    feed_a(16'h0003);
    check("basic_count3", count_a, 3);
    check("basic_not_yet_valid", out_valid_a, 0);
    feed_a(16'h0004);
    check("basic_valid", out_valid_a, 1);
    check("basic_out", out_a, 64'h0001_0002_0003_0004);
    check("basic_count0", count_a, 0);

    // Backpressure: next vector fills while buffer is held
    feed_a(16'h0005);
    check("bp_count1", count_a, 1);
    feed_a(16'h0006);
    feed_a(16'h0007);
    check("bp_count3", count_a, 3);
    check("bp_out_held", out_a, 64'h0001_0002_0003_0004);
    in_valid_a = 1'b1;
    in_a       = 16'h0008;
    #1;
    check("bp_in_ready_low", in_ready_a, 0);
    tick();
    check("bp_stall_count", count_a, 3);
    check("bp_stall_out", out_a, 64'h0001_0002_0003_0004);
    out_ready_a = 1'b1;
    #1;
    check("bp_in_ready_high", in_ready_a, 1);
    tick();
    in_valid_a = 1'b0;
    check("bp_new_out", out_a, 64'h0005_0006_0007_0008);
    check("bp_no_bubble", out_valid_a, 1);
    check("bp_count_wrap", count_a, 0);
    tick();
    check("bp_drained", out_valid_a, 0);
    check("bp_out_kept", out_a, 64'h0005_0006_0007_0008);

    // Streaming: 12 words with out_ready held high
    for (int k = 1; k <= 12; k++) begin
      in_valid_a = 1'b1;
      in_a       = 16'(16'h0010 + k - 1);
      #1;
      check("stream_in_ready", in_ready_a, 1);
      tick();
      check("stream_out_valid", out_valid_a, (k % 4 == 0) ? 1 : 0);
      if (k == 4)  check("stream_vec1", out_a, pack4(16'h0010, 16'h0011, 16'h0012, 16'h0013));
      if (k == 8)  check("stream_vec2", out_a, pack4(16'h0014, 16'h0015, 16'h0016, 16'h0017));
      if (k == 12) check("stream_vec3", out_a, pack4(16'h0018, 16'h0019, 16'h001a, 16'h001b));
    end
    in_valid_a = 1'b0;
    tick();
    check("stream_idle", out_valid_a, 0);
    out_ready_a = 1'b0;

    // Clear drops the partial vector and the word offered with it
    feed_a(16'h0021);
    feed_a(16'h0022);
    check("clr_count2", count_a, 2);
    clear_a    = 1'b1;
    in_valid_a = 1'b1;
    in_a       = 16'h0099;
    tick();
    clear_a    = 1'b0;
    in_valid_a = 1'b0;
    check("clr_count0", count_a, 0);
    check("clr_out_valid", out_valid_a, 0);
    feed_a(16'h0031);
    feed_a(16'h0032);
    feed_a(16'h0033);
    feed_a(16'h0034);
    check("clr_next_valid", out_valid_a, 1);
    check("clr_next_out", out_a, 64'h0031_0032_0033_0034);

    // Clear also drops a held output
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_drop_valid", out_valid_a, 0);
    feed_a(16'h0035);
    feed_a(16'h0036);
    feed_a(16'h0037);
    feed_a(16'h0038);
    check("clr2_out", out_a, 64'h0035_0036_0037_0038);

    // Async reset mid-cycle with count = 2 and out_valid = 1
    feed_a(16'h0041);
    feed_a(16'h0042);
    check("ar_pre_count", count_a, 2);
    check("ar_pre_valid", out_valid_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_count", count_a, 0);
    check("ar_valid", out_valid_a, 0);
    check("ar_out", out_a, 0);
    // No accept while reset is held across an edge
    in_valid_a = 1'b1;
    in_a       = 16'h00ee;
    tick();
    check("ar_no_accept", count_a, 0);
    in_valid_a = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    feed_a(16'h0051);
    feed_a(16'h0052);
    feed_a(16'h0053);
    feed_a(16'h0054);
    check("ar_after_valid", out_valid_a, 1);
    check("ar_after_out", out_a, 64'h0051_0052_0053_0054);

    // Round trip on the 32-word instance
    for (int i = 0; i < 16; i++) vec[i*32 +: 32] = $urandom;
    check("rt_in_ready", in_ready_b, 1);
    for (int i = 0; i < 32; i++) begin
      in_valid_b = 1'b1;
      in_b       = vec[511 - 16*i -: 16];
      tick();
      if (i == 30) begin
        check("rt_count31", count_b, 31);
        check("rt_not_yet", out_valid_b, 0);
      end
    end
    in_valid_b = 1'b0;
    check("rt_valid", out_valid_b, 1);
    check("rt_out", out_b, vec);
    check("rt_count0", count_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
